alu_flag_unit: RTL and testbench
================================

# alu_flag_unit

Consumer end of the 64-bit ALU status interface. Captures the ALU's negative/zero/overflow/carry_out outputs into an architectural flag register on flag-setting instructions. Resolves conditional branches (B.cond) against the stored flags, and compare-and-branch (CBZ/CBNZ) against the live ALU zero output. Sits between the ALU and the PC-select logic of the non-pipelined 64-bit CPU, and produces one registered branch decision per request.

## Interface
Parameters:
- FLAG_RESET, 4'b0000, reset value of {N,Z,V,C}
- NV_IS_ALWAYS, 1, when 1 cond 4'b1111 behaves as AL; when 0 it is never-taken

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high; sampled on rising clk
- negative  in  1  ALU negative flag, current cycle
- zero  in  1  ALU zero flag, current cycle
- overflow  in  1  ALU overflow flag, current cycle
- carry_out  in  1  ALU carry_out flag, current cycle
- set_flags  in  1  load ALU flags into flag register at this edge
- cond_valid  in  1  B.cond request this cycle
- cond  in  4  LEGv8 condition code
- cbz_valid  in  1  CBZ/CBNZ request this cycle
- cbz_not  in  1  0 = CBZ (taken if zero), 1 = CBNZ (taken if !zero)
- flags  out  4  registered {N,Z,V,C}
- branch_valid  out  1  decision valid, one cycle after request
- take_branch  out  1  decision; 0 whenever branch_valid = 0
- req_error  out  1  pulses with branch_valid when cond_valid and cbz_valid were both high

## Operation
- Flag register: on rising clk, if set_flags, {N,Z,V,C} <= {negative,zero,overflow,carry_out}; otherwise the register holds its value.
- B.cond evaluates against the registered flags (the value before any same-edge update). Codes:
  - 0000 EQ: Z; 0001 NE: !Z
  - 0010 HS: C; 0011 LO: !C
  - 0100 MI: N; 0101 PL: !N
  - 0110 VS: V; 0111 VC: !V
  - 1000 HI: C&!Z; 1001 LS: !(C&!Z)
  - 1010 GE: N==V; 1011 LT: N!=V
  - 1100 GT: !Z&(N==V); 1101 LE: Z|(N!=V)
  - 1110 AL: 1; 1111 per NV_IS_ALWAYS
- CBZ/CBNZ evaluates the live zero input in the request cycle. The flag register is neither read nor written, unless set_flags is also asserted.
- Decision state machine, two states:
  - IDLE: any request goes to RESP.
  - RESP: branch_valid=1 and take_branch is the latched result. A request in the same cycle stays in RESP, so back-to-back requests give back-to-back decisions. No request returns to IDLE.
- Simultaneous cond_valid and cbz_valid: the CBZ request wins, and req_error=1 in the response cycle.
- The decision is registered, so the ALU input changing after the request edge does not alter take_branch.

## Timing
- Reset, synchronous: flags=FLAG_RESET, branch_valid=0, take_branch=0, req_error=0, state=IDLE. Reset overrides set_flags and any request on the same edge.
- Reset asserted while in RESP: the outputs clear at that edge and the pending decision is discarded.
- Flag latency: flags update 1 cycle after set_flags is sampled.
- Decision latency: exactly 1 cycle from the request edge to branch_valid.
- set_flags together with cond_valid on the same edge: cond uses the old flags; flags shows the new value next cycle.
- Throughput: 1 decision per cycle; there is no stall and no backpressure.

## Structure
- A shared package holds:
  - condition-code enum (EQ..NV, 4 bits)
  - flag index constants: N=3, Z=2, V=1, C=0
  - FSM state enum: IDLE, RESP
- Sub-module cond_eval: combinational. Takes flags[3:0], cond[3:0] and the NV_IS_ALWAYS parameter, and returns the taken bit. It is reused by future pipelined branch logic.
- The top level contains the flag register, the request mux, the FSM and the output registers.

## Test plan
- Reset, then set_flags with N=0 Z=1 V=0 C=1 → next cycle flags=4'b0101. A cond=0000 (EQ) request → branch_valid=1, take_branch=1 one cycle later.
- flags=4'b1000 (N=1, V=0) → cond=1011 (LT) taken; cond=1010 (GE) not taken; cond=1100 (GT) not taken.
- cbz_valid with cbz_not=0 and zero=1 → taken. With cbz_not=1 and zero=1 → not taken. flags stay unchanged in both cases.
- set_flags with zero=1 on the same edge as cond=0000, old Z=0 → take_branch=0. Next cycle flags[2]=1, and a second EQ request is taken.
- cond_valid and cbz_valid together, zero=0, cbz_not=1 → take_branch=1, req_error=1.
- Three back-to-back requests followed by reset asserted in the third response cycle → branch_valid is high for 2 cycles, then 0. flags=FLAG_RESET.

Source files
------------

// File: rtl/alu_flag_unit_pkg.sv
// rtl/alu_flag_unit_pkg.sv - shared types and constants for the ALU flag unit
package alu_flag_unit_pkg;

   // LEGv8 condition codes for B.cond
   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_HS = 4'b0010,
      COND_LO = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

   // Bit positions inside the {N,Z,V,C} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_C = 0;

   // Decision state machine
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

endpackage

// File: rtl/alu_flag_unit_cond_eval.sv
// rtl/alu_flag_unit_cond_eval.sv - combinational B.cond evaluation against {N,Z,V,C}
module alu_flag_unit_cond_eval
   import alu_flag_unit_pkg::*;
#(
   parameter bit NV_IS_ALWAYS = 1'b1
) (
   input  logic [3:0] flags_i,
   input  logic [3:0] cond_i,
   output logic       taken_o
);

   logic n, z, v, c;

   assign n = flags_i[FLAG_N];
   assign z = flags_i[FLAG_Z];
   assign v = flags_i[FLAG_V];
   assign c = flags_i[FLAG_C];

   // Decode the condition code into a taken bit
   always_comb begin
      taken_o = 1'b0;
      case (cond_e'(cond_i))
         COND_EQ: taken_o = z;
         COND_NE: taken_o = ~z;
         COND_HS: taken_o = c;
         COND_LO: taken_o = ~c;
         COND_MI: taken_o = n;
         COND_PL: taken_o = ~n;
         COND_VS: taken_o = v;
         COND_VC: taken_o = ~v;
         COND_HI: taken_o = c & ~z;
         COND_LS: taken_o = ~(c & ~z);
         COND_GE: taken_o = (n == v);
         COND_LT: taken_o = (n != v);
         COND_GT: taken_o = ~z & (n == v);
         COND_LE: taken_o = z | (n != v);
         COND_AL: taken_o = 1'b1;
         COND_NV: taken_o = NV_IS_ALWAYS;
         default: taken_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_flag_unit.sv
// rtl/alu_flag_unit.sv - flag register and registered branch decision for the ALU status interface
module alu_flag_unit
   import alu_flag_unit_pkg::*;
#(
   parameter logic [3:0] FLAG_RESET   = 4'b0000,
   parameter bit         NV_IS_ALWAYS = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       negative,
   input  logic       zero,
   input  logic       overflow,
   input  logic       carry_out,
   input  logic       set_flags,
   input  logic       cond_valid,
   input  logic [3:0] cond,
   input  logic       cbz_valid,
   input  logic       cbz_not,
   output logic [3:0] flags,
   output logic       branch_valid,
   output logic       take_branch,
   output logic       req_error
);

   logic [3:0] flags_q, flags_d;
   state_e     state_q, state_d;
   logic       take_q, take_d;
   logic       err_q, err_d;
   logic       any_req;
   logic       cond_taken;
   logic       req_result;

   // B.cond always sees the flags as stored before this edge's update
   alu_flag_unit_cond_eval #(
      .NV_IS_ALWAYS(NV_IS_ALWAYS)
   ) u_cond_eval (
      .flags_i(flags_q),
      .cond_i (cond),
      .taken_o(cond_taken)
   );

   // Request mux: CBZ/CBNZ wins over B.cond and uses the live zero input
   always_comb begin
      any_req    = cond_valid | cbz_valid;
      req_result = cbz_valid ? (cbz_not ? ~zero : zero) : cond_taken;
      take_d     = any_req & req_result;
      err_d      = cond_valid & cbz_valid;
      flags_d    = set_flags ? {negative, zero, overflow, carry_out} : flags_q;
   end

   // State, flag and decision registers; reset discards any pending decision
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         flags_q <= FLAG_RESET;
         take_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         take_q  <= take_d;
         err_q   <= err_d;
      end
   end

   // Next state: every request produces a response cycle, back-to-back if needed
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = any_req ? ST_RESP : ST_IDLE;
         ST_RESP: state_d = any_req ? ST_RESP : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs: decision fields are forced low outside the response cycle
   always_comb begin
      flags        = flags_q;
      branch_valid = (state_q == ST_RESP);
      take_branch  = branch_valid & take_q;
      req_error    = branch_valid & err_q;
   end

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb/tb_alu_flag_unit.sv - self-checking bench for alu_flag_unit with directed and random steps
module tb_alu_flag_unit;

   localparam logic [3:0] P_FLAG_RESET = 4'b0000;
   localparam bit         P_NV_ALWAYS  = 1'b1;

   logic       clk = 1'b0;
   logic       reset, negative, zero, overflow, carry_out, set_flags;
   logic       cond_valid, cbz_valid, cbz_not;
   logic [3:0] cond;
   logic [3:0] flags;
   logic       branch_valid, take_branch, req_error;

   int checks = 0;
   int errors = 0;

   // Reference state
   logic [3:0] m_flags;
   logic       e_bv, e_take, e_err;

   alu_flag_unit #(
      .FLAG_RESET  (P_FLAG_RESET),
      .NV_IS_ALWAYS(P_NV_ALWAYS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .negative    (negative),
      .zero        (zero),
      .overflow    (overflow),
      .carry_out   (carry_out),
      .set_flags   (set_flags),
      .cond_valid  (cond_valid),
      .cond        (cond),
      .cbz_valid   (cbz_valid),
      .cbz_not     (cbz_not),
      .flags       (flags),
      .branch_valid(branch_valid),
      .take_branch (take_branch),
      .req_error   (req_error)
   );

   always #5 clk = ~clk;

   // Condition semantics written as predicate pairs: odd codes negate the even one
   function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] cc);
      logic n, z, v, c, base;
      n = f[3]; z = f[2]; v = f[1]; c = f[0];
      case (cc >> 1)
         0: base = z;
         1: base = c;
         2: base = n;
         3: base = v;
         4: base = c && !z;
         5: base = (n == v);
         6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (cc == 4'd15)
         return P_NV_ALWAYS;
      else if (cc == 4'd14)
         return 1'b1;
      return base ^ cc[0];
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic sf, input logic [3:0] nzvc,
                        input logic cv, input logic [3:0] cc,
                        input logic bv, input logic bn);
      reset = rst; set_flags = sf;
      {negative, zero, overflow, carry_out} = nzvc;
      cond_valid = cv; cond = cc; cbz_valid = bv; cbz_not = bn;
   endtask

   // Advance one edge, update the model from the inputs seen at that edge, then compare
   task automatic cycle();
      logic [3:0] nf;
      if (reset) begin
         nf = P_FLAG_RESET; e_bv = 0; e_take = 0; e_err = 0;
      end else begin
         nf     = set_flags ? {negative, zero, overflow, carry_out} : m_flags;
         e_bv   = cond_valid | cbz_valid;
         e_err  = cond_valid & cbz_valid;
         if (cbz_valid)       e_take = cbz_not ? !zero : zero;
         else if (cond_valid) e_take = ref_cond(m_flags, cond);
         else                 e_take = 1'b0;
      end
      @(posedge clk);
      #1;
      m_flags = nf;
      chk("flags", flags, m_flags);
      chk("branch_valid", {3'b0, branch_valid}, {3'b0, e_bv});
      chk("take_branch", {3'b0, take_branch}, {3'b0, e_take});
      chk("req_error", {3'b0, req_error}, {3'b0, e_err});
   endtask

   initial begin
      m_flags = 4'hx;
      drive(1, 0, 4'h0, 0, 4'h0, 0, 0);
      cycle();
      chk("reset_flags", flags, P_FLAG_RESET);
      chk("reset_bv", {3'b0, branch_valid}, 4'h0);

      // set N=0 Z=1 V=0 C=1, then EQ
      drive(0, 1, 4'b0101, 0, 4'h0, 0, 0); cycle();
      chk("flags_0101", flags, 4'b0101);
      drive(0, 0, 4'b0000, 1, 4'b0000, 0, 0); cycle();
      chk("eq_taken", {2'b0, branch_valid, take_branch}, 4'b0011);

      // N=1 V=0: LT taken, GE and GT not
      drive(0, 1, 4'b1000, 0, 4'h0, 0, 0); cycle();
      drive(0, 0, 4'b0000, 1, 4'b1011, 0, 0); cycle();
      chk("lt_taken", {3'b0, take_branch}, 4'h1);
      drive(0, 0, 4'b0000, 1, 4'b1010, 0, 0); cycle();
      chk("ge_not", {2'b0, branch_valid, take_branch}, 4'b0010);
      drive(0, 0, 4'b0000, 1, 4'b1100, 0, 0); cycle();
      chk("gt_not", {2'b0, branch_valid, take_branch}, 4'b0010);

      // CBZ / CBNZ with zero=1, flags untouched
      drive(0, 0, 4'b0100, 0, 4'h0, 1, 0); cycle();
      chk("cbz_taken", {3'b0, take_branch}, 4'h1);
      chk("cbz_flags", flags, 4'b1000);
      drive(0, 0, 4'b0100, 0, 4'h0, 1, 1); cycle();
      chk("cbnz_not", {2'b0, branch_valid, take_branch}, 4'b0010);
      chk("cbnz_flags", flags, 4'b1000);

      // Same-edge set_flags and EQ uses old Z=0
      drive(0, 1, 4'b0100, 1, 4'b0000, 0, 0); cycle();
      chk("eq_old_flags", {2'b0, branch_valid, take_branch}, 4'b0010);
      chk("new_z", {3'b0, flags[2]}, 4'h1);
      drive(0, 0, 4'b0000, 1, 4'b0000, 0, 0); cycle();
      chk("eq_new_flags", {3'b0, take_branch}, 4'h1);

      // Simultaneous requests: CBNZ wins, error flagged
      drive(0, 0, 4'b0000, 1, 4'b0000, 1, 1); cycle();
      chk("both_take", {3'b0, take_branch}, 4'h1);
      chk("both_err", {3'b0, req_error}, 4'h1);
      drive(0, 0, 4'b0000, 0, 4'h0, 0, 0); cycle();
      chk("idle_err", {3'b0, req_error}, 4'h0);

      // Back-to-back requests, reset on the third request edge
      drive(0, 0, 4'b0000, 1, 4'b1110, 0, 0); cycle();
      chk("b2b_1", {3'b0, branch_valid}, 4'h1);
      drive(0, 0, 4'b0000, 1, 4'b1110, 0, 0); cycle();
      chk("b2b_2", {3'b0, branch_valid}, 4'h1);
      drive(1, 1, 4'b1111, 1, 4'b1110, 1, 0); cycle();
      chk("b2b_reset_bv", {3'b0, branch_valid}, 4'h0);
      chk("b2b_reset_flags", flags, P_FLAG_RESET);
      drive(0, 0, 4'b0000, 0, 4'h0, 0, 0); cycle();
      chk("post_reset_bv", {3'b0, branch_valid}, 4'h0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1), 4'($urandom),
               ($urandom_range(0, 2) != 0), 4'($urandom),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
